// File: rtl/fifo_word_serializer.sv
// Drains 32-bit words from the upstream FIFO and replays each one as four
// bytes on a valid/ready byte stream, tracking completed words and read faults.
module fifo_word_serializer #(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fifo_empty,
   input  logic [31:0] fifo_d_out,
   input  logic        fifo_rd_ack,
   input  logic        fifo_rd_err,
   output logic        fifo_rd_en,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   output logic        byte_last,
   input  logic        byte_ready,
   output logic        busy,
   output logic [15:0] word_count,
   output logic        rd_fault
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_SEND = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [31:0] word_q, word_d;
   logic [15:0] word_count_q, word_count_d;
   logic        rd_fault_q, rd_fault_d;
   logic        accept;

   function automatic logic [7:0] select_byte(input logic [31:0] w, input logic [1:0] i);
      logic [1:0] pos;
      pos = MSB_FIRST ? (2'd3 - i) : i;
      case (pos)
         2'd0:    select_byte = w[7:0];
         2'd1:    select_byte = w[15:8];
         2'd2:    select_byte = w[23:16];
         default: select_byte = w[31:24];
      endcase
   endfunction

   assign accept = (state_q == ST_SEND) && byte_ready;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      word_d       = word_q;
      word_count_d = word_count_q;
      rd_fault_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) state_d = ST_REQ;
         end
         ST_REQ: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // Ack has priority over err; an error and a missing ack both fault.
            if (fifo_rd_ack) begin
               word_d  = fifo_d_out;
               idx_d   = 2'd0;
               state_d = ST_SEND;
            end else begin
               rd_fault_d = fifo_rd_err | ~fifo_rd_ack;
               state_d    = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (accept) begin
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  word_count_d = word_count_q + 16'd1;
                  state_d      = fifo_empty ? ST_IDLE : ST_REQ;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= 2'd0;
         word_q       <= 32'd0;
         word_count_q <= 16'd0;
         rd_fault_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         word_q       <= word_d;
         word_count_q <= word_count_d;
         rd_fault_q   <= rd_fault_d;
      end
   end

   // All outputs decode registered state, so none depends combinationally on inputs.
   assign fifo_rd_en = (state_q == ST_REQ);
   assign byte_valid = (state_q == ST_SEND);
   assign byte_last  = (state_q == ST_SEND) && (idx_q == 2'd3);
   assign byte_out   = (state_q == ST_SEND) ? select_byte(word_q, idx_q) : 8'h00;
   assign busy       = (state_q != ST_IDLE);
   assign word_count = word_count_q;
   assign rd_fault   = rd_fault_q;

endmodule

// File: doc/fifo_word_serializer.md
# fifo_word_serializer

Downstream drain stage for the 32-bit, 8-entry `fifo`. Pulls words out of the FIFO through its `rd_en`/`rd_ack`/`rd_err` handshake and emits each word as four bytes on a valid/ready byte stream. Uses the FIFO status outputs, so it never issues a read on an empty FIFO in normal operation. Feeds byte-wide consumers such as a UART transmitter or a narrow bus bridge.

## Interface
- `MSB_FIRST`, 0: byte order. 0 sends `[7:0]` first; 1 sends `[31:24]` first.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `fifo_empty` input 1: FIFO `empty` flag.
- `fifo_d_out` input 32: FIFO `d_out`.
- `fifo_rd_ack` input 1: FIFO `rd_ack`.
- `fifo_rd_err` input 1: FIFO `rd_err`.
- `fifo_rd_en` output 1: FIFO `rd_en`, driven from a registered state, high for exactly one cycle per read.
- `byte_out` output 8: current byte.
- `byte_valid` output 1: `byte_out` is valid.
- `byte_last` output 1: high with the 4th byte of a word.
- `byte_ready` input 1: consumer accepts the byte when `byte_valid && byte_ready` at an edge.
- `busy` output 1: high in any state other than IDLE.
- `word_count` output 16: number of words fully sent (4th byte accepted); wraps from 0xFFFF to 0x0000.
- `rd_fault` output 1: one-cycle pulse when a read completes with `rd_err` or with no ack.

## Operation
- States: IDLE, REQ, WAIT, SEND. A 2-bit byte index selects the byte inside SEND.
- IDLE: when `fifo_empty==0` is sampled, go to REQ.
- REQ: `fifo_rd_en=1` for this cycle only, then go to WAIT unconditionally.
- WAIT: the FIFO response is visible this cycle.
  - `fifo_rd_ack=1`: capture `fifo_d_out` into a 32-bit word register, set index to 0, go to SEND.
  - `fifo_rd_err=1`, or neither ack nor err: pulse `rd_fault` in the next cycle, go to IDLE, capture nothing.
  - If ack and err are both high, ack wins.
- SEND: `byte_valid=1`.
  - `byte_out` is byte `index` of the word register, reversed when `MSB_FIRST=1`.
  - `byte_last=1` when index is 3.
  - On each accept (`byte_valid && byte_ready`), index increments.
  - `byte_out`, `byte_valid` and `byte_last` hold stable while `byte_ready` is low. `byte_valid` never drops without an accept.
- Accept of byte 3: `word_count` increments. Next state is REQ if `fifo_empty==0` at that edge, else IDLE (back-to-back path skips IDLE).
- `fifo_d_out` is ignored outside WAIT. `fifo_empty` is ignored outside IDLE and the byte-3 accept edge.
- Reset, at any time including mid-word: state IDLE, index 0, word register 0, `word_count` 0.
  - A captured word not yet fully sent is dropped. It has already left the FIFO and is lost by design.

## Timing
- Reset values: `fifo_rd_en=0`, `byte_out=0x00`, `byte_valid=0`, `byte_last=0`, `busy=0`, `word_count=0`, `rd_fault=0`.
- Latency, with `fifo_empty` first sampled low at edge k:
  - `fifo_rd_en` high in cycle k+1.
  - Capture at edge k+2.
  - First `byte_valid` in cycle k+3.
- Throughput with `byte_ready` held high and the FIFO non-empty: 6 cycles per word (REQ, WAIT, 4×SEND).
- `word_count` updates at the edge that accepts byte 3.
- `rd_fault` is high the cycle after the failing WAIT, coincident with IDLE.
- Exactly one `fifo_rd_en` pulse per REQ visit. Never two consecutive cycles high.

## Test plan
- Reset then idle: `reset=1` for 2 cycles, `fifo_empty=1` → all outputs at reset values; `fifo_rd_en` stays 0 for 20 cycles.
- Single word, `MSB_FIRST=0`, `byte_ready=1`, FIFO returns 0x44332211 with `rd_ack`:
  - `byte_out` is 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - `byte_last` is high only with 0x44.
  - `word_count=1`; first byte 3 cycles after `fifo_empty` falls.
- Backpressure: same word with `byte_ready` low for 3 cycles during byte 0x22 → 0x22 and `byte_valid` held stable; no byte skipped or repeated.
- Back-to-back with `MSB_FIRST=1`: FIFO holds 0x000000AA and 0x000000BB, `byte_ready=1`:
  - Bytes are 00 00 00 AA 00 00 00 BB.
  - `fifo_rd_en` pulses are 6 cycles apart; `word_count=2`.
- Read error: FIFO answers the REQ with `rd_err=1` → `rd_fault` one-cycle pulse, no `byte_valid`, return to IDLE, `word_count` unchanged.
- Reset mid-word: `reset=1` while byte 0x33 of 0x44332211 is pending → next cycle all outputs at reset values; with `fifo_empty=1`, no further bytes appear.
